reminder_countdown: RTL and testbench

//  Drink-reminder countdown timer. Counts a programmed interval down to 00:00 as
//  MM:SS, one step per second, and raises a latched alert when it expires.

---
 rtl/reminder_countdown.sv | 177 +++++++++++++++++
 tb/tb_reminder_countdown.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/reminder_countdown.sv
// ---------------------------------------------------------------------------
// reminder_countdown
//   Drink-reminder countdown timer. A programmed interval (whole minutes) is
//   counted down to 00:00 as MM:SS, one step per second. When it expires, a
//   latched alert is raised. Acknowledging the alert reloads the interval and
//   restarts the countdown, or returns to IDLE if the interval is zero.
//   minutes/seconds stay within 0..59, so they can feed a 6-bit binary-to-BCD
//   display stage directly.
//
// Parameters
//   TICKS_PER_SEC : clk cycles per one-second step (>= 2)
//   MAX_MIN       : largest accepted interval in minutes (<= 59)
//
// Ports
//   clk      in   system clock, rising edge
//   reset    in   synchronous active-high reset, returns to IDLE
//   start    in   pulse: begin from IDLE or resume from PAUSED
//   pause    in   pulse: freeze the countdown (RUN only)
//   ack      in   pulse: clear alert, reload and restart (ALERT only)
//   set_min  in   interval in minutes, sampled on start (IDLE) and on ack
//   minutes  out  remaining minutes, binary 0..59
//   seconds  out  remaining seconds, binary 0..59
//   running  out  1 while in RUN
//   alert    out  1 while in ALERT
// ---------------------------------------------------------------------------
module reminder_countdown #(
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int MAX_MIN       = 59
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       pause,
    input  logic       ack,
    input  logic [5:0] set_min,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic       running,
    output logic       alert
);

    localparam int              PW        = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0]   P_LAST    = PW'(TICKS_PER_SEC - 1);
    localparam logic [5:0]      MAX_MIN_L = 6'(MAX_MIN);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2,
        S_ALERT  = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [PW-1:0] r_presc;
    logic [5:0]    r_min;
    logic [5:0]    r_sec;
    logic          r_running;
    logic          r_alert;

    logic [5:0]    w_load_val;
    logic          w_load_ok;
    logic          w_sec_tick;
    logic          w_expire;
    logic          w_load;
    logic          w_running_nxt;
    logic          w_alert_nxt;

    // Interval clamped to MAX_MIN; zero means "nothing to count".
    assign w_load_val = (set_min > MAX_MIN_L) ? MAX_MIN_L : set_min;
    assign w_load_ok  = (w_load_val != 6'd0);

    // The prescaler only advances in RUN, so the tick can only occur there.
    assign w_sec_tick = (r_state == S_RUN) && (r_presc == P_LAST);

    // The only step that lands on 00:00 is 00:01 -> 00:00; a borrow from
    // minutes always leaves seconds at 59.
    assign w_expire   = w_sec_tick && (r_min == 6'd0) && (r_sec == 6'd1);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; only the input meaningful in the current state acts.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && w_load_ok) begin
                    w_state_nxt = S_RUN;
                    w_load      = 1'b1;
                end
            end
            S_RUN: begin
                // Expiry takes precedence: a pause on the final tick must not
                // leave the timer parked at 00:00 without an alert.
                if (w_expire) begin
                    w_state_nxt = S_ALERT;
                end else if (pause) begin
                    w_state_nxt = S_PAUSED;
                end
            end
            S_PAUSED: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_ALERT: begin
                if (ack) begin
                    if (w_load_ok) begin
                        w_state_nxt = S_RUN;
                        w_load      = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Output decode from the next state, registered below so the flags
    // change on the same edge as the state itself.
    always_comb begin
        w_running_nxt = (w_state_nxt == S_RUN);
        w_alert_nxt   = (w_state_nxt == S_ALERT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_running <= 1'b0;
            r_alert   <= 1'b0;
        end else begin
            r_running <= w_running_nxt;
            r_alert   <= w_alert_nxt;
        end
    end

    // Prescaler and MM:SS countdown
    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc <= '0;
            r_min   <= 6'd0;
            r_sec   <= 6'd0;
        end else if (w_load) begin
            r_presc <= '0;
            r_min   <= w_load_val;
            r_sec   <= 6'd0;
        end else if (r_state == S_RUN) begin
            // Counting continues on a pause edge, so a coinciding tick still
            // decrements; PAUSED then holds the prescaler for a clean resume.
            r_presc <= w_sec_tick ? '0 : r_presc + 1'b1;
            if (w_sec_tick) begin
                if (r_sec != 6'd0) begin
                    r_sec <= r_sec - 6'd1;
                end else if (r_min != 6'd0) begin
                    r_min <= r_min - 6'd1;
                    r_sec <= 6'd59;
                end
            end
        end
    end

    assign minutes = r_min;
    assign seconds = r_sec;
    assign running = r_running;
    assign alert   = r_alert;

endmodule

// File: tb/tb_reminder_countdown.sv
module tb_reminder_countdown;

    localparam int TPS = 4;

    logic       clk;
    logic       reset;
    logic       start;
    logic       pause;
    logic       ack;
    logic [5:0] set_min;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       running;
    logic       alert;

    int tests;
    int fails;

    reminder_countdown #(.TICKS_PER_SEC(TPS), .MAX_MIN(59)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .pause   (pause),
        .ack     (ack),
        .set_min (set_min),
        .minutes (minutes),
        .seconds (seconds),
        .running (running),
        .alert   (alert)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: remaining time kept as a single seconds total, with a
    // cycle phase counter standing in for the one-second prescaler.
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_ALERT = 3;
    int m_mode;
    int m_rem;
    int m_phase;

    task automatic model_step(input bit r, input bit s, input bit p, input bit a, input int sm);
        int  lv;
        bit  tk;
        lv = (sm > 59) ? 59 : sm;
        if (r) begin
            m_mode = M_IDLE; m_rem = 0; m_phase = 0;
        end else begin
            case (m_mode)
                M_IDLE: if (s && lv != 0) begin
                    m_rem = lv * 60; m_phase = 0; m_mode = M_RUN;
                end
                M_RUN: begin
                    tk      = (m_phase == TPS - 1);
                    m_phase = (m_phase + 1) % TPS;
                    if (tk) m_rem = m_rem - 1;
                    if (tk && m_rem == 0) m_mode = M_ALERT;
                    else if (p)           m_mode = M_PAUSED;
                end
                M_PAUSED: if (s) m_mode = M_RUN;
                default: if (a) begin
                    if (lv != 0) begin
                        m_rem = lv * 60; m_phase = 0; m_mode = M_RUN;
                    end else begin
                        m_mode = M_IDLE;
                    end
                end
            endcase
        end
    endtask

    // Apply one cycle of inputs; pulses are cleared just after the edge.
    task automatic step(input bit r, input bit s, input bit p, input bit a);
        reset = r; start = s; pause = p; ack = a;
        @(posedge clk);
        model_step(r, s, p, a, int'(set_min));
        #1;
        reset = 1'b0; start = 1'b0; pause = 1'b0; ack = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk_exp(input string nm, input int mm, input int ss, input bit rn, input bit al);
        tests++;
        if (int'(minutes) != mm || int'(seconds) != ss || running !== rn || alert !== al) begin
            fails++;
            $display("FAIL %s: got %0d:%0d run=%0d alert=%0d, want %0d:%0d run=%0d alert=%0d",
                     nm, minutes, seconds, running, alert, mm, ss, rn, al);
        end
    endtask

    task automatic chk_model(input string nm);
        chk_exp(nm, m_rem / 60, m_rem % 60, m_mode == M_RUN, m_mode == M_ALERT);
    endtask

    typedef struct {
        bit       r, s, p, a;
        bit [5:0] sm;
        int       em, es;
        bit       er, ea;
    } vec_t;

    vec_t vt[17];

    initial begin
        tests = 0; fails = 0;
        m_mode = M_IDLE; m_rem = 0; m_phase = 0;
        reset = 1'b1; start = 1'b0; pause = 1'b0; ack = 1'b0; set_min = 6'd0;

        //          r  s  p  a  set  mm ss run al
        vt[0]  = '{1, 0, 0, 0, 0,  0,  0, 0, 0};
        vt[1]  = '{0, 1, 0, 0, 2,  2,  0, 1, 0};
        vt[2]  = '{0, 0, 0, 0, 2,  2,  0, 1, 0};
        vt[3]  = '{0, 0, 0, 0, 2,  2,  0, 1, 0};
        vt[4]  = '{0, 0, 0, 0, 7,  2,  0, 1, 0};
        vt[5]  = '{0, 0, 0, 0, 7,  1, 59, 1, 0};
        vt[6]  = '{0, 0, 1, 0, 7,  1, 59, 0, 0};
        vt[7]  = '{0, 0, 0, 1, 7,  1, 59, 0, 0};
        vt[8]  = '{0, 1, 0, 0, 5,  1, 59, 1, 0};
        vt[9]  = '{0, 0, 0, 0, 5,  1, 59, 1, 0};
        vt[10] = '{0, 0, 0, 0, 5,  1, 59, 1, 0};
        vt[11] = '{0, 0, 0, 0, 5,  1, 58, 1, 0};
        vt[12] = '{0, 1, 1, 0, 5,  1, 58, 0, 0};
        vt[13] = '{1, 0, 0, 0, 5,  0,  0, 0, 0};
        vt[14] = '{0, 1, 0, 0, 0,  0,  0, 0, 0};
        vt[15] = '{0, 1, 0, 0, 63, 59, 0, 1, 0};
        vt[16] = '{1, 0, 0, 0, 63, 0,  0, 0, 0};

        for (int i = 0; i < 17; i++) begin
            set_min = vt[i].sm;
            step(vt[i].r, vt[i].s, vt[i].p, vt[i].a);
            chk_exp($sformatf("vec%0d", i), vt[i].em, vt[i].es, vt[i].er, vt[i].ea);
        end

        // Full one-minute run to expiry
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk_exp("reset_state", 0, 0, 0, 0);
        set_min = 6'd1;
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk_exp("t1_start", 1, 0, 1, 0);
        idle_cycles(4);
        chk_exp("t1_first_sec", 0, 59, 1, 0);
        idle_cycles(235);
        chk_exp("t1_before_exp", 0, 1, 1, 0);
        idle_cycles(1);
        chk_exp("t1_expired", 0, 0, 0, 1);
        idle_cycles(5);
        chk_exp("t1_alert_held", 0, 0, 0, 1);

        // Ack reloads with a new interval
        set_min = 6'd2;
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk_exp("t3_start_pause_ignored", 0, 0, 0, 1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk_exp("t3_ack_reload", 2, 0, 1, 0);
        set_min = 6'd0;
        begin : wait_alert
            int n;
            n = 0;
            while (alert !== 1'b1 && n < 600) begin
                step(1'b0, 1'b0, 1'b0, 1'b0);
                n++;
            end
            tests++;
            if (n != 480) begin
                fails++;
                $display("FAIL t3_alert_latency: got %0d cycles, want 480", n);
            end
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk_exp("t3_ack_zero_idle", 0, 0, 0, 0);

        // Pause / resume keeps the prescaler phase
        set_min = 6'd1;
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle_cycles(14);
        chk_exp("t2_at_0057", 0, 57, 1, 0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        idle_cycles(20);
        chk_exp("t2_paused_hold", 0, 57, 0, 0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk_exp("t2_resumed", 0, 57, 1, 0);
        idle_cycles(1);
        chk_exp("t2_tick_after_resume", 0, 56, 1, 0);

        // Pause coinciding with the second tick
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle_cycles(3);
        chk_exp("t5_pre_tick", 1, 0, 1, 0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk_exp("t5_pause_on_tick", 0, 59, 0, 0);

        // Reset mid-count
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle_cycles(119);
        chk_exp("t6_at_0030", 0, 30, 1, 0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        chk_exp("t6_reset_run", 0, 0, 0, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            bit r, s, p, a;
            set_min = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63))
                                                  : 6'($urandom_range(0, 2));
            r = ($urandom_range(0, 299) == 0);
            s = ($urandom_range(0, 7) == 0);
            p = ($urandom_range(0, 19) == 0);
            a = ($urandom_range(0, 5) == 0);
            step(r, s, p, a);
            chk_model("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
